// File: rtl/hdr_pkg.sv
// hdr_pkg: shared types and constants for the HDR command path.
// The descriptor struct mirrors the register-file byte map, byte 0 in the LSBs.
package hdr_pkg;

  localparam int ATTR_W = 3;
  localparam int TID_W  = 4;
  localparam int CMD_W  = 8;
  localparam int DEV_W  = 5;
  localparam int DTT_W  = 3;
  localparam int MODE_W = 3;
  localparam int RES_W  = 2;

  localparam logic [MODE_W-1:0] HDR_DDR_MODE   = 3'd6;
  localparam logic [ATTR_W-1:0] ATTR_REGULAR   = 3'd0;
  localparam logic [ATTR_W-1:0] ATTR_IMMEDIATE = 3'd1;
  localparam logic [DTT_W-1:0]  IMM_DTT_MAX    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHECK = 3'd3,
    ST_VALID = 3'd4
  } fetch_state_e;

  // 64-bit descriptor, first member is the MSB (byte 7), last member is byte 0 bit 0.
  typedef struct packed {
    logic [7:0]        data_four;   // byte 7
    logic [7:0]        data_three;  // byte 6
    logic [7:0]        data_two;    // byte 5
    logic [7:0]        def_byte;    // byte 4
    logic              toc;         // byte 3
    logic              wroc;
    logic              rnw;
    logic [MODE_W-1:0] mode;
    logic [1:0]        dtt_hi;
    logic              dtt_lo;      // byte 2
    logic [RES_W-1:0]  res;
    logic [DEV_W-1:0]  dev_index;
    logic              cp;          // byte 1
    logic [6:0]        cmd_hi;
    logic              cmd_lo;      // byte 0
    logic [TID_W-1:0]  tid;
    logic [ATTR_W-1:0] attr;
  } hdr_desc_t;

  // Returns 1 when the descriptor must not be handed to the engine.
  function automatic logic desc_reject(input hdr_desc_t d, input logic [MODE_W-1:0] mode_ok);
    logic [DTT_W-1:0] dtt;
    logic             bad_attr;
    logic             bad_res;
    logic             bad_mode;
    logic             bad_imm;
    dtt      = {d.dtt_hi, d.dtt_lo};
    bad_attr = (d.attr != ATTR_REGULAR) && (d.attr != ATTR_IMMEDIATE);
    bad_res  = (d.res != 2'd0);
    bad_mode = (d.mode != mode_ok);
    bad_imm  = (d.attr == ATTR_IMMEDIATE) && (dtt > IMM_DTT_MAX);
    desc_reject = bad_attr | bad_res | bad_mode | bad_imm;
  endfunction

endpackage

// File: rtl/hdr_cmd_desc_fetch.sv
// hdr_cmd_desc_fetch: reads the 8-byte command descriptor from the register
// file, validates it and presents the decoded fields to the HDR engine over
// a valid/ready handshake. Fields are registered and only change on accept.
module hdr_cmd_desc_fetch
  import hdr_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'd1000,
  parameter int                RD_LAT    = 1,
  parameter logic [2:0]        HDR_MODE  = HDR_DDR_MODE
) (
  input  logic              i_sys_clk,
  input  logic              i_rst,
  input  logic              i_fetch_start,
  output logic              o_regf_rd_en,
  output logic [ADDR_W-1:0] o_regf_rd_address,
  input  logic [7:0]        i_regf_data_rd,
  output logic              o_desc_valid,
  input  logic              i_desc_ready,
  output logic [2:0]        o_cmd_attr,
  output logic [3:0]        o_tid,
  output logic [7:0]        o_cmd,
  output logic              o_cp,
  output logic [4:0]        o_dev_index,
  output logic [2:0]        o_dtt,
  output logic [2:0]        o_mode,
  output logic              o_rnw,
  output logic              o_wroc,
  output logic              o_toc,
  output logic [31:0]       o_dword1,
  output logic              o_desc_err,
  output logic              o_busy
);

  fetch_state_e state_q, state_d;

  logic [2:0]        issue_cnt_q, issue_cnt_d;
  logic [2:0]        cap_cnt_q, cap_cnt_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RD_LAT-1:0] rv_q, rv_d;
  logic [63:0]       raw_q, raw_d;
  hdr_desc_t         raw_s;

  logic start_s;
  logic cap_en_s;
  logic cap_last_s;
  logic desc_bad_s;
  logic accept_s;

  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [2:0]  attr_q, attr_d;
  logic [3:0]  tid_q, tid_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        cp_q, cp_d;
  logic [4:0]  dev_q, dev_d;
  logic [2:0]  dtt_q, dtt_d;
  logic [2:0]  mode_q, mode_d;
  logic        rnw_q, rnw_d;
  logic        wroc_q, wroc_d;
  logic        toc_q, toc_d;
  logic [31:0] dword1_q, dword1_d;

  assign raw_s      = hdr_desc_t'(raw_q);
  assign start_s    = (state_q == ST_IDLE) && i_fetch_start;
  // Returned bytes only count while a fetch is in flight; stale data after reset is dropped.
  assign cap_en_s   = rv_q[RD_LAT-1] && ((state_q == ST_READ) || (state_q == ST_DRAIN));
  assign cap_last_s = cap_en_s && (cap_cnt_q == 3'd7);
  assign desc_bad_s = desc_reject(raw_s, HDR_MODE);
  assign accept_s   = (state_q == ST_CHECK) && !desc_bad_s;

  // State register: synchronous reset aborts any fetch in progress.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the fetch sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_fetch_start) state_d = ST_READ;
        else               state_d = ST_IDLE;
      end
      ST_READ: begin
        if (issue_cnt_q == 3'd7) state_d = ST_DRAIN;
        else                     state_d = ST_READ;
      end
      ST_DRAIN: begin
        if (cap_last_s) state_d = ST_CHECK;
        else            state_d = ST_DRAIN;
      end
      ST_CHECK: begin
        if (desc_bad_s) state_d = ST_IDLE;
        else            state_d = ST_VALID;
      end
      ST_VALID: begin
        if (i_desc_ready) state_d = ST_IDLE;
        else              state_d = ST_VALID;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read issue: one byte per cycle at BASE..BASE+7, address wraps at ADDR_W bits.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    if (start_s) begin
      issue_cnt_d = 3'd0;
      rd_en_d     = 1'b1;
      addr_d      = BASE_ADDR;
    end else if (state_q == ST_READ) begin
      if (issue_cnt_q != 3'd7) begin
        issue_cnt_d = issue_cnt_q + 3'd1;
        rd_en_d     = 1'b1;
        addr_d      = BASE_ADDR + ADDR_W'(issue_cnt_d);
      end else begin
        issue_cnt_d = 3'd0;
        rd_en_d     = 1'b0;
      end
    end else begin
      issue_cnt_d = issue_cnt_q;
    end
  end

  // Read-valid shift register: tracks each issued read until its data returns.
  always_comb begin
    rv_d    = '0;
    rv_d[0] = rd_en_q;
    for (int i = 1; i < RD_LAT; i++) begin
      rv_d[i] = rv_q[i-1];
    end
  end

  // Byte capture into the raw descriptor image, byte index from the capture counter.
  always_comb begin
    raw_d     = raw_q;
    cap_cnt_d = cap_cnt_q;
    if (start_s) begin
      cap_cnt_d = 3'd0;
    end else if (cap_en_s) begin
      raw_d[{cap_cnt_q, 3'b000} +: 8] = i_regf_data_rd;
      cap_cnt_d                       = cap_cnt_q + 3'd1;
    end else begin
      cap_cnt_d = cap_cnt_q;
    end
  end

  // Datapath registers for read issue and capture.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      issue_cnt_q <= 3'd0;
      cap_cnt_q   <= 3'd0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      rv_q        <= '0;
      raw_q       <= 64'd0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      rv_q        <= rv_d;
      raw_q       <= raw_d;
    end
  end

  // Output decode: status flags follow the next state, fields load only on accept.
  always_comb begin
    valid_d  = (state_d == ST_VALID);
    err_d    = (state_q == ST_CHECK) && desc_bad_s;
    busy_d   = (state_d != ST_IDLE);
    attr_d   = attr_q;
    tid_d    = tid_q;
    cmd_d    = cmd_q;
    cp_d     = cp_q;
    dev_d    = dev_q;
    dtt_d    = dtt_q;
    mode_d   = mode_q;
    rnw_d    = rnw_q;
    wroc_d   = wroc_q;
    toc_d    = toc_q;
    dword1_d = dword1_q;
    if (accept_s) begin
      attr_d   = raw_s.attr;
      tid_d    = raw_s.tid;
      cmd_d    = {raw_s.cmd_hi, raw_s.cmd_lo};
      cp_d     = raw_s.cp;
      dev_d    = raw_s.dev_index;
      dtt_d    = {raw_s.dtt_hi, raw_s.dtt_lo};
      mode_d   = raw_s.mode;
      rnw_d    = raw_s.rnw;
      wroc_d   = raw_s.wroc;
      toc_d    = raw_s.toc;
      dword1_d = {raw_s.data_four, raw_s.data_three, raw_s.data_two, raw_s.def_byte};
    end else begin
      dword1_d = dword1_q;
    end
  end

  // Output registers.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      attr_q   <= 3'd0;
      tid_q    <= 4'd0;
      cmd_q    <= 8'd0;
      cp_q     <= 1'b0;
      dev_q    <= 5'd0;
      dtt_q    <= 3'd0;
      mode_q   <= 3'd0;
      rnw_q    <= 1'b0;
      wroc_q   <= 1'b0;
      toc_q    <= 1'b0;
      dword1_q <= 32'd0;
    end else begin
      valid_q  <= valid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      attr_q   <= attr_d;
      tid_q    <= tid_d;
      cmd_q    <= cmd_d;
      cp_q     <= cp_d;
      dev_q    <= dev_d;
      dtt_q    <= dtt_d;
      mode_q   <= mode_d;
      rnw_q    <= rnw_d;
      wroc_q   <= wroc_d;
      toc_q    <= toc_d;
      dword1_q <= dword1_d;
    end
  end

  assign o_regf_rd_en      = rd_en_q;
  assign o_regf_rd_address = addr_q;
  assign o_desc_valid      = valid_q;
  assign o_desc_err        = err_q;
  assign o_busy            = busy_q;
  assign o_cmd_attr        = attr_q;
  assign o_tid             = tid_q;
  assign o_cmd             = cmd_q;
  assign o_cp              = cp_q;
  assign o_dev_index       = dev_q;
  assign o_dtt             = dtt_q;
  assign o_mode            = mode_q;
  assign o_rnw             = rnw_q;
  assign o_wroc            = wroc_q;
  assign o_toc             = toc_q;
  assign o_dword1          = dword1_q;

endmodule

// File: tb/tb_hdr_cmd_desc_fetch.sv
// Bench for hdr_cmd_desc_fetch: two instances (read latency 1 and 3) share a
// register-file image; a field-level reference model derives expectations.
module tb_hdr_cmd_desc_fetch;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst     [2];
  logic        start   [2];
  logic        ready   [2];
  logic        rd_en   [2];
  logic [11:0] addr    [2];
  logic [7:0]  rdata   [2];
  logic        valid   [2];
  logic        err     [2];
  logic        busy    [2];
  logic [2:0]  attr_o  [2];
  logic [3:0]  tid_o   [2];
  logic [7:0]  cmd_o   [2];
  logic        cp_o    [2];
  logic [4:0]  dev_o   [2];
  logic [2:0]  dtt_o   [2];
  logic [2:0]  mode_o  [2];
  logic        rnw_o   [2];
  logic        wroc_o  [2];
  logic        toc_o   [2];
  logic [31:0] dw1_o   [2];

  hdr_cmd_desc_fetch #(.RD_LAT(1)) u_dut_lat1 (
    .i_sys_clk(clk), .i_rst(rst[0]), .i_fetch_start(start[0]),
    .o_regf_rd_en(rd_en[0]), .o_regf_rd_address(addr[0]), .i_regf_data_rd(rdata[0]),
    .o_desc_valid(valid[0]), .i_desc_ready(ready[0]),
    .o_cmd_attr(attr_o[0]), .o_tid(tid_o[0]), .o_cmd(cmd_o[0]), .o_cp(cp_o[0]),
    .o_dev_index(dev_o[0]), .o_dtt(dtt_o[0]), .o_mode(mode_o[0]), .o_rnw(rnw_o[0]),
    .o_wroc(wroc_o[0]), .o_toc(toc_o[0]), .o_dword1(dw1_o[0]),
    .o_desc_err(err[0]), .o_busy(busy[0])
  );

  hdr_cmd_desc_fetch #(.RD_LAT(3)) u_dut_lat3 (
    .i_sys_clk(clk), .i_rst(rst[1]), .i_fetch_start(start[1]),
    .o_regf_rd_en(rd_en[1]), .o_regf_rd_address(addr[1]), .i_regf_data_rd(rdata[1]),
    .o_desc_valid(valid[1]), .i_desc_ready(ready[1]),
    .o_cmd_attr(attr_o[1]), .o_tid(tid_o[1]), .o_cmd(cmd_o[1]), .o_cp(cp_o[1]),
    .o_dev_index(dev_o[1]), .o_dtt(dtt_o[1]), .o_mode(mode_o[1]), .o_rnw(rnw_o[1]),
    .o_wroc(wroc_o[1]), .o_toc(toc_o[1]), .o_dword1(dw1_o[1]),
    .o_desc_err(err[1]), .o_busy(busy[1])
  );

  // Register-file model: data appears RD_LAT cycles after a read, junk otherwise.
  logic [7:0] mem  [4096];
  logic [7:0] pipe [2][3];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pipe[d][0] <= rd_en[d] ? mem[addr[d]] : 8'($urandom);
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end
  assign rdata[0] = pipe[0][0];
  assign rdata[1] = pipe[1][2];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: fields and verdict computed arithmetically from the byte map.
  logic [7:0]  cur_b [8];
  logic [31:0] e_attr, e_tid, e_cmd, e_cp, e_dev, e_res, e_dtt, e_mode, e_rnw, e_wroc, e_toc, e_dw1;
  logic        e_ok;

  task automatic model();
    e_attr = 32'(cur_b[0] % 8);
    e_tid  = 32'((cur_b[0] / 8) % 16);
    e_cmd  = 32'(cur_b[0] / 128) + 32'(cur_b[1] % 128) * 2;
    e_cp   = 32'(cur_b[1] / 128);
    e_dev  = 32'(cur_b[2] % 32);
    e_res  = 32'((cur_b[2] / 32) % 4);
    e_dtt  = 32'(cur_b[3] % 4) * 2 + 32'(cur_b[2] / 128);
    e_mode = 32'((cur_b[3] / 4) % 8);
    e_rnw  = 32'((cur_b[3] / 32) % 2);
    e_wroc = 32'((cur_b[3] / 64) % 2);
    e_toc  = 32'(cur_b[3] / 128);
    e_dw1  = 32'(cur_b[4]) + 32'(cur_b[5]) * 256 + 32'(cur_b[6]) * 65536 + 32'(cur_b[7]) * 16777216;
    e_ok   = (e_attr <= 1) && (e_res == 0) && (e_mode == 6) && !((e_attr == 1) && (e_dtt > 4));
  endtask

  task automatic check_fields(input int d);
    chk("attr", 64'(attr_o[d]), 64'(e_attr));
    chk("tid", 64'(tid_o[d]), 64'(e_tid));
    chk("cmd", 64'(cmd_o[d]), 64'(e_cmd));
    chk("cp", 64'(cp_o[d]), 64'(e_cp));
    chk("dev_index", 64'(dev_o[d]), 64'(e_dev));
    chk("dtt", 64'(dtt_o[d]), 64'(e_dtt));
    chk("mode", 64'(mode_o[d]), 64'(e_mode));
    chk("rnw", 64'(rnw_o[d]), 64'(e_rnw));
    chk("wroc", 64'(wroc_o[d]), 64'(e_wroc));
    chk("toc", 64'(toc_o[d]), 64'(e_toc));
    chk("dword1", 64'(dw1_o[d]), 64'(e_dw1));
  endtask

  task automatic check_all_zero(input int d);
    chk("zero_rd_en", 64'(rd_en[d]), 64'd0);
    chk("zero_addr", 64'(addr[d]), 64'd0);
    chk("zero_valid", 64'(valid[d]), 64'd0);
    chk("zero_err", 64'(err[d]), 64'd0);
    chk("zero_busy", 64'(busy[d]), 64'd0);
    chk("zero_fields", 64'({attr_o[d], tid_o[d], cmd_o[d], cp_o[d], dev_o[d], dtt_o[d],
                            mode_o[d], rnw_o[d], wroc_o[d], toc_o[d], dw1_o[d]}), 64'd0);
  endtask

  // One complete fetch; starts and ends on a falling edge so calls chain back-to-back.
  task automatic fetch(input int d, input int hold, input bit early);
    int cyc;
    int lat;
    lat = (d == 0) ? 1 : 3;
    for (int i = 0; i < 8; i++) mem[1000 + i] = cur_b[i];
    model();
    ready[d] = early;
    start[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[d] = 1'b0;
    cyc = 1;
    chk("busy_after_start", 64'(busy[d]), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("rd_en_on", 64'(rd_en[d]), 64'd1);
      chk("rd_addr", 64'(addr[d]), 64'(1000 + i));
      @(negedge clk);
      cyc++;
    end
    chk("rd_en_off", 64'(rd_en[d]), 64'd0);
    while (!valid[d] && !err[d] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(lat + 10));
    chk("valid_rise", 64'(valid[d]), 64'(e_ok));
    chk("err_pulse", 64'(err[d]), 64'(!e_ok));
    if (e_ok) begin
      check_fields(d);
      for (int h = 0; h < (early ? 0 : hold); h++) begin
        start[d] = (h == 1);
        @(negedge clk);
        chk("hold_valid", 64'(valid[d]), 64'd1);
        chk("hold_busy", 64'(busy[d]), 64'd1);
        chk("hold_no_read", 64'(rd_en[d]), 64'd0);
        check_fields(d);
      end
      start[d] = 1'b0;
      ready[d] = 1'b1;
      @(negedge clk);
      ready[d] = 1'b0;
      chk("valid_after_xfer", 64'(valid[d]), 64'd0);
      chk("busy_after_xfer", 64'(busy[d]), 64'd0);
      check_fields(d);
    end else begin
      ready[d] = 1'b0;
      @(negedge clk);
      chk("err_one_cycle", 64'(err[d]), 64'd0);
      chk("no_valid_on_err", 64'(valid[d]), 64'd0);
      chk("idle_after_err", 64'(busy[d]), 64'd0);
    end
  endtask

  // Abort a fetch with reset in its fourth read cycle.
  task automatic reset_mid(input int d);
    bit seen;
    for (int i = 0; i < 8; i++) mem[1000 + i] = cur_b[i];
    start[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[d] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rd_en_before_rst", 64'(rd_en[d]), 64'd1);
    rst[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[d] = 1'b0;
    check_all_zero(d);
    seen = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (valid[d] || err[d] || busy[d]) seen = 1'b1;
    end
    chk("no_partial_desc", 64'(seen), 64'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    check_all_zero(0);
    check_all_zero(1);

    // Regular descriptor with 20 cycles of backpressure.
    cur_b = '{8'h18, 8'h00, 8'h03, 8'h99, 8'h01, 8'h02, 8'h03, 8'h04};
    fetch(0, 20, 1'b0);
    // MODE=5 reject.
    cur_b[3] = 8'h95;
    fetch(0, 0, 1'b0);
    // Immediate with DTT=5 reject.
    cur_b = '{8'h19, 8'h00, 8'h83, 8'h9A, 8'h01, 8'h02, 8'h03, 8'h04};
    fetch(0, 0, 1'b0);
    // Reset mid-fetch after a good descriptor is held, then fetch again with ready pre-asserted.
    cur_b = '{8'h18, 8'h00, 8'h03, 8'h99, 8'h01, 8'h02, 8'h03, 8'h04};
    fetch(0, 2, 1'b0);
    reset_mid(0);
    fetch(0, 0, 1'b1);
    // Read latency 3 instance, same descriptor.
    fetch(1, 3, 1'b0);
    // Back-to-back: second start in the cycle after the handshake, TID=7.
    fetch(0, 1, 1'b0);
    cur_b[0] = 8'h38;
    fetch(0, 0, 1'b0);

    // Randomized descriptors, mostly legal with occasional rule violations.
    for (int n = 0; n < 30; n++) begin
      logic [2:0] a;
      logic [2:0] m;
      logic [2:0] t;
      logic [1:0] r;
      a = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
      m = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd6;
      r = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0;
      t = 3'($urandom);
      cur_b[0] = {1'($urandom), 4'($urandom), a};
      cur_b[1] = 8'($urandom);
      cur_b[2] = {t[0], r, 5'($urandom)};
      cur_b[3] = {3'($urandom), m, t[2:1]};
      for (int i = 4; i < 8; i++) cur_b[i] = 8'($urandom);
      fetch(n % 2, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
